// File: rtl/clock_set_controller_pkg.sv
// Shared types and default constants for the digital-clock set controller.
//   mode_e  : controller mode (RUN=0, SET_HOUR=1, SET_MIN=2)
//   *_DEF   : default divider / timing constants for a 50 MHz clock
//   cnt_w() : counter width for a given modulus (at least one bit)
package clock_set_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_e;

  localparam int unsigned TICK_DIV_DEF    = 50_000_000;
  localparam int unsigned REPEAT_DLY_DEF  = 25_000_000;
  localparam int unsigned REPEAT_RATE_DEF = 5_000_000;
  localparam int unsigned BLINK_DIV_DEF   = 12_500_000;
  localparam int unsigned TIMEOUT_S_DEF   = 30;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_set_controller_if.sv
// Button / counter-chain bundle for clock_set_controller.
//   btn_mode  : one-cycle pulse, advance mode
//   btn_inc   : level, increment selected field while high
//   sec_carry : one-cycle pulse, seconds counter 59->0 wrap
//   carry_min : one-cycle pulse, minute counter 59->0 wrap
//   sec_tick, sec_clr, min_inc, hour_inc : one-cycle pulses to the counters
//   mode      : current controller mode
//   blink     : display blank phase for the field being set
// master = driver of buttons/carries (board side), slave = controller.
interface clock_set_controller_if;
  import clock_set_controller_pkg::*;

  logic  btn_mode;
  logic  btn_inc;
  logic  sec_carry;
  logic  carry_min;
  logic  sec_tick;
  logic  sec_clr;
  logic  min_inc;
  logic  hour_inc;
  mode_e mode;
  logic  blink;

  modport master (
    output btn_mode, btn_inc, sec_carry, carry_min,
    input  sec_tick, sec_clr, min_inc, hour_inc, mode, blink
  );

  modport slave (
    input  btn_mode, btn_inc, sec_carry, carry_min,
    output sec_tick, sec_clr, min_inc, hour_inc, mode, blink
  );

endinterface

// File: rtl/clock_set_controller_prescaler.sv
// Free-running modulo-DIV divider with a registered one-cycle tick.
//   i_clk       : clock
//   i_reset_all : synchronous active-high reset
//   i_clr       : synchronous clear of count and pending tick
//   o_tick      : high for one cycle in the cycle after the count wraps
module clock_set_controller_prescaler
  import clock_set_controller_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic i_clk,
  input  logic i_reset_all,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Count 0..DIV-1 and flag the wrap one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_reset_all || i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == LAST);
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/clock_set_controller.sv
// Mode/sequencing controller for the clock's seconds/minutes/hours counters.
// RUN: generates the 1 Hz seconds enable and forwards counter carries.
// SET_HOUR/SET_MIN: steps the selected field from btn_inc with auto-repeat,
// blinks the field, and falls back to RUN after TIMEOUT_S idle seconds.
//   i_clk       : clock
//   i_reset_all : synchronous active-high reset
//   ctl         : button / counter-chain bundle (slave side)
module clock_set_controller
  import clock_set_controller_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
  parameter int unsigned REPEAT_DLY  = REPEAT_DLY_DEF,
  parameter int unsigned REPEAT_RATE = REPEAT_RATE_DEF,
  parameter int unsigned BLINK_DIV   = BLINK_DIV_DEF,
  parameter int unsigned TIMEOUT_S   = TIMEOUT_S_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_reset_all,
  clock_set_controller_if.slave  ctl
);

  localparam int unsigned RW = cnt_w((REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE);
  localparam int unsigned TW = cnt_w(TIMEOUT_S);

  mode_e         r_mode, w_mode_nxt;
  logic          w_set_mode, w_mode_change, w_leave_min, w_timeout;
  logic          r_inc_d, w_inc_rise, w_inc_pulse;
  logic          r_rep_lock, r_rep_phase, w_rep_hold, w_rep_fire;
  logic [RW-1:0] r_rep_cnt, w_rep_last;
  logic [TW-1:0] r_timeout;
  logic          w_sec_tick_int, w_blink_tick, w_blink_clr;
  logic          r_sec_tick, r_sec_clr, r_min_inc, r_hour_inc, r_blink;

  // Seconds divider: keeps running in set modes to feed the timeout.
  clock_set_controller_prescaler #(.DIV(TICK_DIV)) u_sec_div (
    .i_clk       (i_clk),
    .i_reset_all (i_reset_all),
    .i_clr       (w_leave_min),
    .o_tick      (w_sec_tick_int)
  );

  // Blink divider: held clear in RUN, restarted on every increment.
  clock_set_controller_prescaler #(.DIV(BLINK_DIV)) u_blink_div (
    .i_clk       (i_clk),
    .i_reset_all (i_reset_all),
    .i_clr       (w_blink_clr),
    .o_tick      (w_blink_tick)
  );

  assign w_set_mode    = (r_mode != RUN);
  assign w_inc_rise    = ctl.btn_inc & ~r_inc_d;
  // Increment activity on the same cycle defers the timeout.
  assign w_timeout     = w_set_mode & w_sec_tick_int & ~w_inc_rise &
                         (r_timeout == TW'(TIMEOUT_S - 1));
  assign w_mode_change = (w_mode_nxt != r_mode);
  assign w_leave_min   = (r_mode == SET_MIN) & (w_mode_nxt == RUN);

  // Auto-repeat: initial delay phase, then fixed-rate phase.
  assign w_rep_hold  = ctl.btn_inc & r_inc_d & ~r_rep_lock & w_set_mode;
  assign w_rep_last  = r_rep_phase ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DLY - 1);
  assign w_rep_fire  = w_rep_hold & (r_rep_cnt == w_rep_last);
  // A mode change in the same cycle swallows the increment.
  assign w_inc_pulse = w_set_mode & ~w_mode_change & (w_inc_rise | w_rep_fire);
  assign w_blink_clr = (w_mode_nxt == RUN) | w_inc_pulse;

  // Mode state register.
  always_ff @(posedge i_clk) begin
    if (i_reset_all) r_mode <= RUN;
    else             r_mode <= w_mode_nxt;
  end

  // Next mode: btn_mode advances, timeout returns to RUN.
  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      RUN:      if (ctl.btn_mode) w_mode_nxt = SET_HOUR;
      SET_HOUR: if (ctl.btn_mode) w_mode_nxt = SET_MIN;
                else if (w_timeout) w_mode_nxt = RUN;
      SET_MIN:  if (ctl.btn_mode || w_timeout) w_mode_nxt = RUN;
      default:  w_mode_nxt = RUN;
    endcase
  end

  // Edge detect and auto-repeat; a held button across a mode change is locked out.
  always_ff @(posedge i_clk) begin
    if (i_reset_all) begin
      r_inc_d     <= 1'b0;
      r_rep_lock  <= 1'b0;
      r_rep_phase <= 1'b0;
      r_rep_cnt   <= '0;
    end else begin
      r_inc_d <= ctl.btn_inc;
      if (!ctl.btn_inc)      r_rep_lock <= 1'b0;
      else if (w_mode_change) r_rep_lock <= 1'b1;
      if (w_mode_change || !w_rep_hold) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b0;
      end else if (w_rep_fire) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + RW'(1);
      end
    end
  end

  // Idle-seconds counter for set-mode timeout.
  always_ff @(posedge i_clk) begin
    if (i_reset_all) begin
      r_timeout <= '0;
    end else if (!w_set_mode || w_mode_change || ctl.btn_mode || w_inc_rise) begin
      r_timeout <= '0;
    end else if (w_sec_tick_int) begin
      r_timeout <= r_timeout + TW'(1);
    end
  end

  // Output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset_all) begin
      r_sec_tick <= 1'b0;
      r_sec_clr  <= 1'b0;
      r_min_inc  <= 1'b0;
      r_hour_inc <= 1'b0;
      r_blink    <= 1'b0;
    end else begin
      r_sec_tick <= w_sec_tick_int & (r_mode == RUN);
      r_sec_clr  <= w_leave_min;
      r_min_inc  <= (r_mode == RUN) ? ctl.sec_carry : ((r_mode == SET_MIN) & w_inc_pulse);
      r_hour_inc <= (r_mode == RUN) ? ctl.carry_min : ((r_mode == SET_HOUR) & w_inc_pulse);
      if (w_blink_clr)       r_blink <= 1'b0;
      else if (w_blink_tick) r_blink <= ~r_blink;
    end
  end

  assign ctl.sec_tick = r_sec_tick;
  assign ctl.sec_clr  = r_sec_clr;
  assign ctl.min_inc  = r_min_inc;
  assign ctl.hour_inc = r_hour_inc;
  assign ctl.mode     = r_mode;
  assign ctl.blink    = r_blink;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with small divider values.
module tb_clock_set_controller;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  clock_set_controller_if u_if ();

  clock_set_controller #(
    .TICK_DIV    (10),
    .REPEAT_DLY  (8),
    .REPEAT_RATE (3),
    .BLINK_DIV   (4),
    .TIMEOUT_S   (3)
  ) dut (
    .i_clk       (clk),
    .i_reset_all (rst),
    .ctl         (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    u_if.btn_mode  = 1'b0;
    u_if.btn_inc   = 1'b0;
    u_if.sec_carry = 1'b0;
    u_if.carry_min = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;

    // 1. Reset values, then seconds ticks in RUN.
    do_reset();
    check("rst_mode",  32'(u_if.mode),     32'd0);
    check("rst_tick",  32'(u_if.sec_tick), 32'd0);
    check("rst_clr",   32'(u_if.sec_clr),  32'd0);
    check("rst_min",   32'(u_if.min_inc),  32'd0);
    check("rst_hour",  32'(u_if.hour_inc), 32'd0);
    check("rst_blink", 32'(u_if.blink),    32'd0);
    for (int k = 1; k <= 35; k++) begin
      step();
      check("t1_tick",  32'(u_if.sec_tick), 32'(k == 11 || k == 21 || k == 31));
      check("t1_mode",  32'(u_if.mode),     32'd0);
      check("t1_blink", 32'(u_if.blink),    32'd0);
    end

    // 2. RUN carries forwarded; btn_inc ignored.
    u_if.sec_carry = 1'b1;
    step();
    u_if.sec_carry = 1'b0;
    check("t2_min_a",  32'(u_if.min_inc),  32'd1);
    check("t2_hour_a", 32'(u_if.hour_inc), 32'd0);
    step();
    check("t2_min_b",  32'(u_if.min_inc),  32'd0);
    u_if.carry_min = 1'b1;
    step();
    u_if.carry_min = 1'b0;
    check("t2_hour_c", 32'(u_if.hour_inc), 32'd1);
    check("t2_min_c",  32'(u_if.min_inc),  32'd0);
    step();
    check("t2_hour_d", 32'(u_if.hour_inc), 32'd0);
    u_if.btn_inc = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      check("t2_run_inc", 32'({u_if.hour_inc, u_if.min_inc}), 32'd0);
    end
    u_if.btn_inc = 1'b0;
    step();
    check("t2_mode", 32'(u_if.mode), 32'd0);

    // 3. SET_HOUR with btn_inc held 20 cycles: auto-repeat.
    do_reset();
    u_if.btn_mode = 1'b1;
    step();
    u_if.btn_mode = 1'b0;
    check("t3_mode_in", 32'(u_if.mode), 32'd1);
    u_if.btn_inc = 1'b1;
    for (int j = 1; j <= 22; j++) begin
      step();
      if (j == 20) u_if.btn_inc = 1'b0;
      check("t3_hour", 32'(u_if.hour_inc), 32'(j == 1 || j == 9 || j == 12 || j == 15 || j == 18));
      check("t3_min",  32'(u_if.min_inc),  32'd0);
      check("t3_tick", 32'(u_if.sec_tick), 32'd0);
      check("t3_mode", 32'(u_if.mode),     32'd1);
    end

    // 4. SET_MIN: increment with concurrent carry_min, then exit with sec_clr.
    u_if.btn_mode = 1'b1;
    step();
    u_if.btn_mode = 1'b0;
    check("t4_mode_min", 32'(u_if.mode), 32'd2);
    u_if.btn_inc   = 1'b1;
    u_if.carry_min = 1'b1;
    step();
    u_if.carry_min = 1'b0;
    check("t4_min",  32'(u_if.min_inc),  32'd1);
    check("t4_hour", 32'(u_if.hour_inc), 32'd0);
    step();
    check("t4_min_once", 32'(u_if.min_inc),  32'd0);
    check("t4_hour_b",   32'(u_if.hour_inc), 32'd0);
    u_if.btn_inc = 1'b0;
    step();
    u_if.btn_mode = 1'b1;
    step();
    u_if.btn_mode = 1'b0;
    check("t4_mode_run", 32'(u_if.mode),    32'd0);
    check("t4_clr",      32'(u_if.sec_clr), 32'd1);
    step();
    check("t4_clr_once", 32'(u_if.sec_clr), 32'd0);
    for (int j = 2; j <= 12; j++) begin
      step();
      check("t4_first_tick", 32'(u_if.sec_tick), 32'(j == 11));
    end

    // 5. SET_HOUR idle: timeout after 3 internal ticks, blink pattern, no sec_clr.
    do_reset();
    u_if.btn_mode = 1'b1;
    step();
    u_if.btn_mode = 1'b0;
    check("t5_mode_in", 32'(u_if.mode),  32'd1);
    check("t5_blink_1", 32'(u_if.blink), 32'd0);
    for (int k = 2; k <= 42; k++) begin
      step();
      check("t5_mode",  32'(u_if.mode),     (k <= 30) ? 32'd1 : 32'd0);
      check("t5_blink", 32'(u_if.blink),    (k <= 30) ? 32'(((k - 1) / 4) % 2 == 1) : 32'd0);
      check("t5_clr",   32'(u_if.sec_clr),  32'd0);
      check("t5_tick",  32'(u_if.sec_tick), 32'(k == 41));
    end

    // 6. btn_mode wins over simultaneous btn_inc edge; held button locked out; reset mid-set.
    do_reset();
    u_if.btn_mode = 1'b1;
    step();
    u_if.btn_inc = 1'b1;
    step();
    u_if.btn_mode = 1'b0;
    check("t6_mode",  32'(u_if.mode),     32'd2);
    check("t6_hour",  32'(u_if.hour_inc), 32'd0);
    check("t6_min",   32'(u_if.min_inc),  32'd0);
    for (int j = 0; j < 10; j++) begin
      step();
      check("t6_lock", 32'({u_if.hour_inc, u_if.min_inc}), 32'd0);
    end
    u_if.btn_inc = 1'b0;
    step();
    u_if.btn_inc = 1'b1;
    step();
    u_if.btn_inc = 1'b0;
    check("t6_min_rise", 32'(u_if.min_inc), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_mode",  32'(u_if.mode),    32'd0);
    check("t6_rst_clr",   32'(u_if.sec_clr), 32'd0);
    check("t6_rst_min",   32'(u_if.min_inc), 32'd0);
    step();
    check("t6_post_mode", 32'(u_if.mode),    32'd0);
    check("t6_post_clr",  32'(u_if.sec_clr), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
